intersect_scheduler: RTL

Round-robin scheduler that shares one bitmask-intersection engine among NUM_REQ sparse-fibre requesters in the LoAS datapath. It accepts one job (spike bitmask A, weight bitmask B) at a time, forms A & B, and streams every matched position with its compressed weight-fibre offset over a valid/ready port. A completion pulse reports the match count per job. It sits between the per-PE fibre fetch units and the shared accumulate stage.

---
 rtl/intersect_scheduler_pkg.sv | 19 +
 rtl/intersect_scheduler_if.sv | 36 +++
 rtl/intersect_scheduler_prefix_offset_unit.sv | 49 ++++
 rtl/intersect_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/intersect_scheduler_pkg.sv
// Shared types and sizing for the LoAS bitmask-intersection scheduler.
package intersect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_BITMASK_WIDTH = 128;

  function automatic int pos_w(input int width);
    return $clog2(width);
  endfunction

  localparam int POS_W = pos_w(DEF_BITMASK_WIDTH);

endpackage

// File: rtl/intersect_scheduler_if.sv
// Requester, match-beat and completion signals of the intersection scheduler.
interface intersect_scheduler_if
  import intersect_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int BITMASK_WIDTH = DEF_BITMASK_WIDTH
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW   = pos_w(BITMASK_WIDTH);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*BITMASK_WIDTH-1:0] req_bitmask_a;
  logic [NUM_REQ*BITMASK_WIDTH-1:0] req_bitmask_b;
  logic                             out_valid;
  logic                             out_ready;
  logic [ID_W-1:0]                  out_req_id;
  logic [PW-1:0]                    out_position;
  logic [PW-1:0]                    out_offset;
  logic                             out_last;
  logic                             done_valid;
  logic [ID_W-1:0]                  done_req_id;
  logic [PW:0]                      done_count;

  modport slave (
    input  req_valid, req_bitmask_a, req_bitmask_b, out_ready,
    output req_ready, out_valid, out_req_id, out_position, out_offset,
           out_last, done_valid, done_req_id, done_count
  );

  modport master (
    output req_valid, req_bitmask_a, req_bitmask_b, out_ready,
    input  req_ready, out_valid, out_req_id, out_position, out_offset,
           out_last, done_valid, done_req_id, done_count
  );
endinterface

// File: rtl/intersect_scheduler_prefix_offset_unit.sv
// Combinational: lowest set bit of remaining, popcount of B up to that bit minus one,
// and a flag for "remaining has exactly one bit set".
module prefix_offset_unit
  import intersect_pkg::*;
#(
  parameter  int WIDTH = DEF_BITMASK_WIDTH,
  localparam int PW    = pos_w(WIDTH)
) (
  input  logic [WIDTH-1:0] remaining,
  input  logic [WIDTH-1:0] bitmask_b,
  output logic [PW-1:0]    position,
  output logic [PW-1:0]    offset,
  output logic             single
);
  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] prefix_mask;
  logic [WIDTH-1:0] hits;

  // Two's-complement trick isolates the lowest one; lowest-1 fills every bit below it.
  assign lowest      = remaining & (~remaining + WIDTH'(1));
  assign prefix_mask = lowest | (lowest - WIDTH'(1));
  assign hits        = bitmask_b & prefix_mask;
  assign single      = (remaining != '0) && ((remaining & (remaining - WIDTH'(1))) == '0);

  always_comb begin
    position = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lowest[i]) position = position | PW'(i);
    end
  end

  // Balanced adder tree: level l holds WIDTH>>l partial sums.
  for (genvar l = 0; l <= PW; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [N-1:0][PW:0] s;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i] = {{PW{1'b0}}, hits[i]};
      end
    end else begin : g_node
      for (genvar i = 0; i < N; i++) begin : g_sum
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign offset = PW'(g_lvl[PW].s[0] - (PW+1)'(1));

endmodule

// File: rtl/intersect_scheduler.sv
// Round-robin sharing of one bitmask-intersection engine; streams A&B matches with B offsets.
// Optional SCHED_PERF_EN adds perf_jobs / perf_stall counters.
module intersect_scheduler
  import intersect_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int BITMASK_WIDTH = DEF_BITMASK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  intersect_scheduler_if.slave  bus
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]           perf_jobs,
  output logic [31:0]           perf_stall
`endif
);
  localparam int W  = BITMASK_WIDTH;
  localparam int PW = pos_w(W);
  localparam int IW = $clog2(NUM_REQ);

  state_e         state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  job_id_q, job_id_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [PW:0]    count_q, count_d;

  logic           any_vld;
  logic [IW-1:0]  win_id;
  logic [W-1:0]   win_a, win_b, win_and;
  logic [PW-1:0]  lo_pos, lo_off;
  logic           lo_single;

  logic [NUM_REQ-1:0] req_ready_c;
  logic               out_valid_c, out_last_c, done_valid_c;
  logic [IW-1:0]      out_req_id_c, done_req_id_c;
  logic [PW-1:0]      out_position_c, out_offset_c;
  logic [PW:0]        done_count_c;

  prefix_offset_unit #(.WIDTH(W)) u_pou (
    .remaining (rem_q),
    .bitmask_b (b_q),
    .position  (lo_pos),
    .offset    (lo_off),
    .single    (lo_single)
  );

  // Walk from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    int idx;
    idx     = 0;
    any_vld = 1'b0;
    win_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) begin
        any_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  assign win_a   = bus.req_bitmask_a[int'(win_id)*W +: W];
  assign win_b   = bus.req_bitmask_b[int'(win_id)*W +: W];
  assign win_and = win_a & win_b;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    job_id_d       = job_id_q;
    b_d            = b_q;
    rem_d          = rem_q;
    count_d        = count_q;
    req_ready_c    = '0;
    out_valid_c    = 1'b0;
    out_req_id_c   = '0;
    out_position_c = '0;
    out_offset_c   = '0;
    out_last_c     = 1'b0;
    done_valid_c   = 1'b0;
    done_req_id_c  = '0;
    done_count_c   = '0;
    case (state_q)
      IDLE: begin
        if (any_vld && !rst) begin
          req_ready_c[win_id] = 1'b1;
          job_id_d = win_id;
          b_d      = win_b;
          rem_d    = win_and;
          count_d  = '0;
          rr_ptr_d = (win_id == IW'(NUM_REQ - 1)) ? '0 : win_id + IW'(1);
          state_d  = (win_and != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        out_valid_c    = 1'b1;
        out_req_id_c   = job_id_q;
        out_position_c = lo_pos;
        out_offset_c   = lo_off;
        out_last_c     = lo_single;
        if (bus.out_ready) begin
          rem_d   = rem_q & (rem_q - W'(1));
          count_d = count_q + (PW+1)'(1);
          if (lo_single) state_d = DONE;
        end
      end
      DONE: begin
        done_valid_c  = 1'b1;
        done_req_id_c = job_id_q;
        done_count_c  = count_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      job_id_q <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      job_id_q <= job_id_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_req_id   = out_req_id_c;
  assign bus.out_position = out_position_c;
  assign bus.out_offset   = out_offset_c;
  assign bus.out_last     = out_last_c;
  assign bus.done_valid   = done_valid_c;
  assign bus.done_req_id  = done_req_id_c;
  assign bus.done_count   = done_count_c;

`ifdef SCHED_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_jobs_d  = perf_jobs_q + {31'd0, done_valid_c};
    perf_stall_d = perf_stall_q + {31'd0, out_valid_c & ~bus.out_ready};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_jobs_q  <= perf_jobs_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
